// File: rtl/quadrature_decoder.sv
// quadrature_decoder: synchronizes and debounces the two raw phases of a
// rotary encoder, decodes them in 4x mode into a one-cycle step pulse plus a
// held direction level, and flags illegal (both-phase) transitions.
module quadrature_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic encoderA,
   input  logic encoderB,
   input  logic clearError,
   output logic stepEnable,
   output logic stepDirection,
   output logic filteredA,
   output logic filteredB,
   output logic errorFlag
);

   localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned START_W = $clog2(DEBOUNCE_CYCLES + 3);
   localparam logic [CNT_W-1:0]   DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [START_W-1:0] START_LAST = START_W'(DEBOUNCE_CYCLES + 2);

   typedef enum logic [1:0] {
      MOVE_NONE    = 2'd0,
      MOVE_UP      = 2'd1,
      MOVE_DOWN    = 2'd2,
      MOVE_ILLEGAL = 2'd3
   } move_e;

   // Classify a {A,B} transition: up is 00->10->11->01->00, down is the reverse,
   // and a change of both bits at once cannot come from a real encoder.
   function automatic move_e classify_move(input logic [1:0] prev_v, input logic [1:0] cur_v);
      move_e m;
      case ({prev_v, cur_v})
         4'b0010, 4'b1011, 4'b1101, 4'b0100: m = MOVE_UP;
         4'b0001, 4'b0111, 4'b1110, 4'b1000: m = MOVE_DOWN;
         4'b0011, 4'b1100, 4'b1001, 4'b0110: m = MOVE_ILLEGAL;
         default:                            m = MOVE_NONE;
      endcase
      return m;
   endfunction

   // Next {filtered, counter} of one phase: a new level is accepted only after
   // DEBOUNCE_CYCLES consecutive mismatching samples.
   function automatic logic [CNT_W:0] debounce_next(input logic sync_v, input logic filt_v,
                                                    input logic [CNT_W-1:0] cnt_v);
      logic [CNT_W:0] r;
      if (sync_v == filt_v) begin
         r = {filt_v, {CNT_W{1'b0}}};
      end else if (cnt_v == DB_LAST) begin
         r = {sync_v, {CNT_W{1'b0}}};
      end else begin
         r = {filt_v, cnt_v + CNT_W'(1)};
      end
      return r;
   endfunction

   // Phase vectors are packed as {A, B}.
   logic [1:0]         meta_q;
   logic [1:0]         sync_q;
   logic [1:0]         filt_q, filt_d;
   logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
   logic [START_W-1:0] start_q, start_d;
   logic               armed_q, armed_d;
   logic [1:0]         prev_q, prev_d;
   logic               step_q, step_d;
   logic               dir_q, dir_d;
   logic               err_q, err_d;
   move_e              move_s;

   // Debounce both synchronized phases.
   always_comb begin
      filt_d  = filt_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      {filt_d[1], cnt_a_d} = debounce_next(sync_q[1], filt_q[1], cnt_a_q);
      {filt_d[0], cnt_b_d} = debounce_next(sync_q[0], filt_q[0], cnt_b_q);
   end

   // Arming, 4x decode and sticky error. A cycle that already carries a step
   // pulse does not consume the next transition: prevAB is held so a change
   // arriving right behind it is decoded one cycle later, keeping pulses apart.
   always_comb begin
      move_s  = classify_move(prev_q, filt_q);
      start_d = start_q;
      armed_d = armed_q;
      prev_d  = prev_q;
      step_d  = 1'b0;
      dir_d   = dir_q;
      if (clearError) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
      if (!armed_q) begin
         prev_d = filt_q;
         if (start_q == START_LAST) begin
            armed_d = 1'b1;
         end else begin
            start_d = start_q + START_W'(1);
         end
      end else if (step_q) begin
         prev_d = prev_q;
      end else begin
         prev_d = filt_q;
         case (move_s)
            MOVE_UP: begin
               step_d = 1'b1;
               dir_d  = 1'b1;
            end
            MOVE_DOWN: begin
               step_d = 1'b1;
               dir_d  = 1'b0;
            end
            MOVE_ILLEGAL: begin
               err_d = 1'b1;
            end
            default: begin
               step_d = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous reset; the first two stages form the synchronizer.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q  <= 2'b00;
         sync_q  <= 2'b00;
         filt_q  <= 2'b00;
         cnt_a_q <= {CNT_W{1'b0}};
         cnt_b_q <= {CNT_W{1'b0}};
         start_q <= {START_W{1'b0}};
         armed_q <= 1'b0;
         prev_q  <= 2'b00;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         meta_q  <= {encoderA, encoderB};
         sync_q  <= meta_q;
         filt_q  <= filt_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         start_q <= start_d;
         armed_q <= armed_d;
         prev_q  <= prev_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   assign stepEnable    = step_q;
   assign stepDirection = dir_q;
   assign filteredA     = filt_q[1];
   assign filteredB     = filt_q[0];
   assign errorFlag     = err_q;

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Front-end stage for the up/down counter. It takes the two raw, asynchronous phase signals from a mechanical rotary encoder, synchronizes and debounces them, and decodes the quadrature sequence in 4x mode. Its outputs are a one-cycle step pulse and a held direction level, which drive the counter's `enable` and `direction` inputs directly. It also flags illegal transitions on a sticky error output.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive mismatching cycles required before a filtered phase accepts a new level. Legal range is 2..1023.

- `clock` in 1: single clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `encoderA` in 1: raw phase A, asynchronous to `clock`.
- `encoderB` in 1: raw phase B, asynchronous to `clock`.
- `clearError` in 1: synchronous clear for `errorFlag`.
- `stepEnable` out 1: one-cycle pulse per valid quadrature edge. Connects to counter `enable`.
- `stepDirection` out 1: 1 = up (A leads B), 0 = down. Holds its last value. Connects to counter `direction`.
- `filteredA` out 1: debounced phase A.
- `filteredB` out 1: debounced phase B.
- `errorFlag` out 1: sticky; set on an illegal transition.

## Operation
- **Reset values:** every output is 0. All internal registers are 0: sync flops, filtered levels, debounce counters, previous state `prevAB`, and `armed`.
- **Synchronizer:** a 2-flop chain per phase, giving `syncA` and `syncB`.
- **Debounce, per phase, with counter width clog2(DEBOUNCE_CYCLES+1):**
  - If `sync == filtered`: counter <= 0.
  - Else if `counter == DEBOUNCE_CYCLES-1`: `filtered <= sync` and counter <= 0.
  - Else: counter <= counter+1.
- **Arming:**
  - A startup counter runs for DEBOUNCE_CYCLES+3 cycles after `reset` deasserts.
  - While not armed, `prevAB <= {filteredA,filteredB}` every cycle. No pulse is generated and no error is flagged.
  - `armed` is set on the edge where the startup count completes.
  - Purpose: an encoder resting at any position at power-up produces no spurious step or error.
- **Decode (armed):** compare `cur={filteredA,filteredB}` with `prevAB` each cycle, and set `prevAB <= cur`.
  - Up sequence: 00→10→11→01→00. Result: `stepEnable<=1`, `stepDirection<=1`.
  - Down sequence: 00→01→11→10→00. Result: `stepEnable<=1`, `stepDirection<=0`.
  - `cur == prevAB`: `stepEnable<=0`, and direction is held.
  - Both bits differ (00↔11, 10↔01): `stepEnable<=0`, direction is held, `errorFlag<=1`.
- **errorFlag:**
  - Set by an illegal transition.
  - Cleared by `clearError` on the next edge.
  - If an illegal transition and `clearError` occur in the same cycle, the flag is set (set wins).
  - Cleared by reset.
- **Reset mid-operation:** all state returns to reset values on that edge, and arming restarts. A pulse that was in flight is dropped.

## Timing
- **Edge to pulse:** the raw phase changes between edges 0 and 1 and then stays stable.
  - `sync` updates at edge 2.
  - `filtered` updates at edge D+2.
  - `stepEnable` is high from edge D+3 to edge D+4 (exactly one cycle).
  - `stepDirection` becomes valid at the same edge as `stepEnable` and holds afterwards.
- **Glitch rejection:** a raw pulse shorter than D cycles (as seen at `sync`) never changes `filtered`.
- **Maximum step rate:** one step per D+1 cycles per phase. Faster input is treated as bounce.
- **Error timing:** an illegal transition sets `errorFlag` at the same edge a pulse would have occurred (D+3).
- **Counter throughput:** `stepEnable` is never high in two consecutive cycles, so the downstream counter sees one increment per pulse.

## Test plan
1. **Idle at 00:** reset, hold A=B=0 for 200 cycles → `stepEnable`, `errorFlag`, `filteredA` and `filteredB` stay 0 throughout.
2. **Idle at 11:** reset with A=B=1 held → after arming, `filteredA=filteredB=1`, with no pulse and `errorFlag=0`.
3. **Forward rotation, D=16:** drive 00→10→11→01→00, each level held 40 cycles → 4 pulses, each 19 edges after its input change, `stepDirection=1`. An attached 8-bit counter reads 4.
4. **Reverse rotation, D=16:** drive 00→01→11→10→00 → 4 pulses with `stepDirection=0`. The attached counter wraps from 0 to 252.
5. **Glitch rejection, D=16:** raise A for 15 cycles, then drop it → no pulse and `filteredA` stays 0. Repeat with A held for 16 cycles → exactly one pulse, `stepDirection=1`.
6. **Illegal transition:** change A and B together 00→11 → no pulse, `errorFlag=1` at edge 19.
   - Pulse `clearError` → `errorFlag=0` one edge later.
   - Repeat, asserting `clearError` in the same cycle as the error → `errorFlag` stays 1.
   - Assert reset mid-sequence → all outputs 0 next edge.
